// File: rtl/reg_dump_reader.sv
// reg_dump_reader
//   Walks a register file read port from FIRST_REG to LAST_REG and streams
//   each word out over a valid/ready interface. Each word costs one READ
//   cycle, which captures the read port, and at least one SEND cycle, which
//   waits for the handshake.
//
//   Optional feature: define REG_DUMP_CHECKSUM_EN to append one extra word
//   after LAST_REG. That word carries the XOR of all dumped words, has
//   out_index=5'h1F and is the only word with out_last set.
//
// Parameters
//   FIRST_REG  first register index dumped (0..31)
//   LAST_REG   last register index dumped (FIRST_REG..31)
// Ports
//   clk        rising-edge clock
//   clrn       asynchronous active-low reset
//   start      dump request, sampled in IDLE only
//   abort      cancel the dump in progress
//   rd_data    register file read data, combinational from rd_addr
//   out_ready  consumer accepts the current word
//   rd_addr    register file read address
//   out_valid  out_data/out_index/out_last valid
//   out_data   dumped word
//   out_index  register index of out_data
//   out_last   final word of the dump
//   busy       dump in progress
//   done       one-cycle pulse at normal completion
module reg_dump_reader #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] rd_data,
  input  logic        out_ready,
  output logic [4:0]  rd_addr,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [4:0]  out_index,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] FIRST_A = 5'(FIRST_REG);
  localparam logic [4:0] LAST_A  = 5'(LAST_REG);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  state_t      state, state_d;
  logic [4:0]  rd_addr_d;
  logic        out_valid_d;
  logic [31:0] out_data_d;
  logic [4:0]  out_index_d;
  logic        out_last_d;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [31:0] csum, csum_d;
  // Set once the LAST_REG word has been accepted; the next READ then emits
  // the checksum word instead of sampling the read port.
  logic        csum_phase, csum_phase_d;
`endif

  always_comb begin
    state_d     = state;
    rd_addr_d   = rd_addr;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_index_d = out_index;
    out_last_d  = out_last;
`ifdef REG_DUMP_CHECKSUM_EN
    csum_d       = csum;
    csum_phase_d = csum_phase;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_d   = READ;
          rd_addr_d = FIRST_A;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d       = '0;
          csum_phase_d = 1'b0;
`endif
        end
      end
      READ: begin
        if (abort) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d = '0;
`endif
        end else begin
          state_d     = SEND;
          out_valid_d = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          if (csum_phase) begin
            out_data_d  = csum;
            out_index_d = 5'h1F;
            out_last_d  = 1'b1;
          end else begin
            out_data_d  = rd_data;
            out_index_d = rd_addr;
            out_last_d  = 1'b0;
            csum_d      = csum ^ rd_data;
          end
`else
          out_data_d  = rd_data;
          out_index_d = rd_addr;
          out_last_d  = (rd_addr == LAST_A);
`endif
        end
      end
      SEND: begin
        if (abort) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d = '0;
`endif
        end else if (out_valid && out_ready) begin
          out_valid_d = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
          if (csum_phase) begin
            state_d = DONE;
          end else if (rd_addr == LAST_A) begin
            state_d      = READ;
            csum_phase_d = 1'b1;
          end else begin
            state_d   = READ;
            rd_addr_d = rd_addr + 5'd1;
          end
`else
          if (rd_addr == LAST_A) begin
            state_d = DONE;
          end else begin
            state_d   = READ;
            rd_addr_d = rd_addr + 5'd1;
          end
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum       <= '0;
      csum_phase <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      rd_addr   <= rd_addr_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_index <= out_index_d;
      out_last  <= out_last_d;
`ifdef REG_DUMP_CHECKSUM_EN
      csum       <= csum_d;
      csum_phase <= csum_phase_d;
`endif
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
